// File: rtl/spike_detector_thr.sv
// Threshold spike detector: flags each over-threshold excursion with its peak magnitude,
// then holds off for DEAD_TIME samples. Optional SPIKE_DET_TIMESTAMP_EN adds a TIMESTAMP output.
module spike_detector_thr #(
  parameter int BITWIDTH    = 16,
  parameter bit SIGNED_DATA = 1'b1,
  parameter int DEAD_TIME   = 32,
  parameter int MAX_WIDTH   = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 EN,
  input  logic                 DATA_VALID_IN,
  input  logic [BITWIDTH-1:0]  DATA_IN,
  input  logic [BITWIDTH-2:0]  THRESHOLD,
  output logic                 SPIKE_FLAG,
  output logic [BITWIDTH-2:0]  PEAK_OUT,
  output logic [CNT_WIDTH-1:0] SPIKE_CNT,
  output logic                 BUSY
`ifdef SPIKE_DET_TIMESTAMP_EN
  ,
  output logic [31:0]          TIMESTAMP
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PEAK, S_DEAD} state_t;

  localparam logic [7:0] LP_MAX_WIDTH = 8'(MAX_WIDTH);
  localparam logic [7:0] LP_DEAD_TIME = 8'(DEAD_TIME);

  state_t               r_state;
  logic                 r_flag;
  logic                 r_busy;
  logic [BITWIDTH-2:0]  r_peak;
  logic [BITWIDTH-2:0]  r_peak_out;
  logic [CNT_WIDTH-1:0] r_spike_cnt;
  logic [7:0]           r_width_cnt;
  logic [7:0]           r_dead_cnt;

  logic [BITWIDTH-1:0]  w_sample;
  logic [BITWIDTH-1:0]  w_neg;
  logic [BITWIDTH-2:0]  w_mag;
  logic [BITWIDTH-2:0]  w_peak_max;
  logic [BITWIDTH-2:0]  w_end_peak;
  logic [7:0]           w_width_next;
  logic [7:0]           w_dead_next;
  logic                 w_valid;
  logic                 w_above;
  logic                 w_start;
  logic                 w_end;

  // Offset-binary becomes two's complement by flipping the MSB (subtracting midscale).
  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    w_sample = SIGNED_DATA ? DATA_IN : {~DATA_IN[BITWIDTH-1], DATA_IN[BITWIDTH-2:0]};
    w_neg    = -w_sample;
    w_mag    = w_sample[BITWIDTH-2:0];
    if (w_sample[BITWIDTH-1]) begin
      if (w_sample[BITWIDTH-2:0] == '0) w_mag = '1;
      else                              w_mag = w_neg[BITWIDTH-2:0];
    end
  end

  assign w_valid      = EN && DATA_VALID_IN;
  assign w_above      = w_mag > THRESHOLD;
  assign w_peak_max   = (w_mag > r_peak) ? w_mag : r_peak;
  assign w_width_next = r_width_cnt + 8'd1;
  assign w_dead_next  = r_dead_cnt + 8'd1;
  assign w_start      = (r_state == S_ARMED) && w_valid && w_above;
  assign w_end        = ((r_state == S_PEAK) && w_valid &&
                         (!w_above || (w_width_next >= LP_MAX_WIDTH))) ||
                        (w_start && (LP_MAX_WIDTH <= 8'd1));
  assign w_end_peak   = (r_state == S_PEAK) ? w_peak_max : w_mag;

  // NOTE: reset is synchronous, so it lives inside the clocked block rather than its sensitivity list.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_flag      <= 1'b0;
      r_busy      <= 1'b0;
      r_peak      <= '0;
      r_peak_out  <= '0;
      r_spike_cnt <= '0;
      r_width_cnt <= '0;
      r_dead_cnt  <= '0;
    end else begin
      r_flag <= 1'b0;
      if (!EN) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else if (w_end) begin
        r_flag     <= 1'b1;
        r_peak     <= w_end_peak;
        r_peak_out <= w_end_peak;
        if (r_spike_cnt != '1) r_spike_cnt <= r_spike_cnt + 1'b1;
        r_dead_cnt <= '0;
        r_state    <= S_DEAD;
        r_busy     <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_ARMED;
            r_busy  <= 1'b0;
          end
          S_ARMED: begin
            if (w_start) begin
              r_peak      <= w_mag;
              r_width_cnt <= 8'd1;
              r_state     <= S_PEAK;
              r_busy      <= 1'b1;
            end
          end
          S_PEAK: begin
            if (w_valid) begin
              r_peak      <= w_peak_max;
              r_width_cnt <= w_width_next;
            end
          end
          S_DEAD: begin
            // Samples during dead time only advance the hold-off counter.
            if (w_valid) begin
              r_dead_cnt <= w_dead_next;
              if (w_dead_next >= LP_DEAD_TIME) begin
                r_state <= S_ARMED;
                r_busy  <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SPIKE_FLAG = r_flag;
  assign PEAK_OUT   = r_peak_out;
  assign SPIKE_CNT  = r_spike_cnt;
  assign BUSY       = r_busy;

`ifdef SPIKE_DET_TIMESTAMP_EN
  logic [31:0] r_sample_cnt;
  logic [31:0] r_ts_start;
  logic [31:0] r_timestamp;

  // Each event is stamped with the sample index of the sample that opened it.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_sample_cnt <= '0;
      r_ts_start   <= '0;
      r_timestamp  <= '0;
    end else begin
      if (w_valid) r_sample_cnt <= r_sample_cnt + 32'd1;
      if (w_start) r_ts_start <= r_sample_cnt;
      if (w_end)   r_timestamp <= (r_state == S_PEAK) ? r_ts_start : r_sample_cnt;
    end
  end

  assign TIMESTAMP = r_timestamp;
`endif

endmodule

// File: tb/tb_spike_detector_thr.sv
// Directed bench for spike_detector_thr: table of {inputs, expected outputs} plus
// hand-written forced-end and abort sequences.
module tb_spike_detector_thr;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        EN = 1'b0;
  logic        DATA_VALID_IN = 1'b0;
  logic [15:0] DATA_IN = '0;
  logic [14:0] THRESHOLD = '0;
  logic        SPIKE_FLAG;
  logic [14:0] PEAK_OUT;
  logic [15:0] SPIKE_CNT;
  logic        BUSY;
`ifdef SPIKE_DET_TIMESTAMP_EN
  logic [31:0] TIMESTAMP;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  spike_detector_thr #(
    .BITWIDTH(16), .SIGNED_DATA(1'b1), .DEAD_TIME(4), .MAX_WIDTH(8), .CNT_WIDTH(16)
  ) dut (
    .CLK(CLK), .nRST(nRST), .EN(EN), .DATA_VALID_IN(DATA_VALID_IN),
    .DATA_IN(DATA_IN), .THRESHOLD(THRESHOLD), .SPIKE_FLAG(SPIKE_FLAG),
    .PEAK_OUT(PEAK_OUT), .SPIKE_CNT(SPIKE_CNT), .BUSY(BUSY)
`ifdef SPIKE_DET_TIMESTAMP_EN
    , .TIMESTAMP(TIMESTAMP)
`endif
  );

  typedef struct {
    logic        en;
    logic        v;
    logic [15:0] d;
    logic [14:0] thr;
    logic        f;
    logic [14:0] p;
    logic [15:0] c;
    logic        b;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic f, input logic [14:0] p,
                            input logic [15:0] c, input logic b);
    check({tag, " flag"}, 32'(SPIKE_FLAG), 32'(f));
    check({tag, " peak"}, 32'(PEAK_OUT),   32'(p));
    check({tag, " cnt"},  32'(SPIKE_CNT),  32'(c));
    check({tag, " busy"}, 32'(BUSY),       32'(b));
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic apply(input logic en, input logic v, input logic [15:0] d, input logic [14:0] thr);
    EN = en; DATA_VALID_IN = v; DATA_IN = d; THRESHOLD = thr;
    @(negedge CLK);
  endtask

  task automatic add(input logic en, input logic v, input logic [15:0] d, input logic [14:0] thr,
                     input logic f, input logic [14:0] p, input logic [15:0] c, input logic b);
    vec_t r;
    r.en = en; r.v = v; r.d = d; r.thr = thr; r.f = f; r.p = p; r.c = c; r.b = b;
    vecs.push_back(r);
  endtask

  initial begin
    int flags;

    // Disabled: full-scale strobes must not move anything.
    repeat (3) add(0, 1, 16'h7FFF, 15'd100, 0, 15'd0, 16'd0, 0);
    // Enable (IDLE -> ARMED), then basic event 10,150,300,200,50.
    add(1, 0, 16'd0,   15'd100, 0, 15'd0,   16'd0, 0);
    add(1, 1, 16'd10,  15'd100, 0, 15'd0,   16'd0, 0);
    add(1, 1, 16'd150, 15'd100, 0, 15'd0,   16'd0, 1);
    add(1, 1, 16'd300, 15'd100, 0, 15'd0,   16'd0, 1);
    add(1, 1, 16'd200, 15'd100, 0, 15'd0,   16'd0, 1);
    add(1, 1, 16'd50,  15'd100, 1, 15'd300, 16'd1, 1);
    // Dead time: four 500s ignored, fifth retriggers, 20 ends second event.
    add(1, 1, 16'd500, 15'd100, 0, 15'd300, 16'd1, 1);
    add(1, 1, 16'd500, 15'd100, 0, 15'd300, 16'd1, 1);
    add(1, 1, 16'd500, 15'd100, 0, 15'd300, 16'd1, 1);
    add(1, 1, 16'd500, 15'd100, 0, 15'd300, 16'd1, 0);
    add(1, 1, 16'd500, 15'd100, 0, 15'd300, 16'd1, 1);
    add(1, 1, 16'd20,  15'd100, 1, 15'd500, 16'd2, 1);
    add(1, 0, 16'd0,   15'd100, 0, 15'd500, 16'd2, 1);
    add(1, 1, 16'd0,   15'd100, 0, 15'd500, 16'd2, 1);
    add(1, 1, 16'd0,   15'd100, 0, 15'd500, 16'd2, 1);
    add(1, 1, 16'd0,   15'd100, 0, 15'd500, 16'd2, 1);
    add(1, 1, 16'd0,   15'd100, 0, 15'd500, 16'd2, 0);
    // Equal to threshold (positive and negative) does not trigger.
    add(1, 1, 16'd100,   15'd100, 0, 15'd500, 16'd2, 0);
    add(1, 1, 16'hFF9C,  15'd100, 0, 15'd500, 16'd2, 0);
    // Most-negative sample saturates to 0x7FFF and beats threshold 32766.
    add(1, 1, 16'h8000, 15'd32766, 0, 15'd500,    16'd2, 1);
    add(1, 1, 16'd0,    15'd32766, 1, 15'h7FFF,   16'd3, 1);
    repeat (3) add(1, 1, 16'd0, 15'd100, 0, 15'h7FFF, 16'd3, 1);
    add(1, 1, 16'd0,    15'd100, 0, 15'h7FFF, 16'd3, 0);
    // Negative excursion -101 with threshold 100.
    add(1, 1, 16'hFF9B, 15'd100, 0, 15'h7FFF, 16'd3, 1);
    add(1, 1, 16'd0,    15'd100, 1, 15'd101,  16'd4, 1);
    repeat (3) add(1, 1, 16'd0, 15'd100, 0, 15'd101, 16'd4, 1);
    add(1, 1, 16'd0,    15'd100, 0, 15'd101,  16'd4, 0);

    @(negedge CLK);
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    check_outs("reset", 0, 15'd0, 16'd0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].en, vecs[i].v, vecs[i].d, vecs[i].thr);
      check_outs($sformatf("row%0d", i), vecs[i].f, vecs[i].p, vecs[i].c, vecs[i].b);
    end

    // Forced end: 20 back-to-back 1000s -> flags after the 8th and 20th samples.
    flags = 0;
    for (int k = 1; k <= 20; k++) begin
      apply(1, 1, 16'd1000, 15'd100);
      if (SPIKE_FLAG) flags++;
      if (k == 8)  check_outs("force8",  1, 15'd1000, 16'd5, 1);
      if (k == 7)  check_outs("force7",  0, 15'd101,  16'd4, 1);
      if (k == 12) check_outs("force12", 0, 15'd1000, 16'd5, 0);
      if (k == 20) check_outs("force20", 1, 15'd1000, 16'd6, 1);
    end
    check("force flag count", 32'(flags), 32'd2);
    repeat (4) apply(1, 1, 16'd0, 15'd100);
    check_outs("force rearm", 0, 15'd1000, 16'd6, 0);

    // Abort: EN drops mid-PEAK, no flag, count kept.
    apply(1, 1, 16'd150, 15'd100);
    apply(1, 1, 16'd300, 15'd100);
    check_outs("abort peak", 0, 15'd1000, 16'd6, 1);
    apply(0, 0, 16'd0, 15'd100);
    check_outs("abort idle", 0, 15'd1000, 16'd6, 0);
    apply(1, 0, 16'd0, 15'd100);
    apply(1, 1, 16'd150, 15'd100);
    check_outs("reen peak", 0, 15'd1000, 16'd6, 1);
    apply(1, 1, 16'd0, 15'd100);
    check_outs("reen end", 1, 15'd150, 16'd7, 1);
    apply(1, 0, 16'd0, 15'd100);
    check_outs("reen pulse", 0, 15'd150, 16'd7, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_detector_thr.md
Name: spike_detector_thr

Overview:
Threshold spike detector placed directly downstream of the moving-average filter stage. It consumes one filtered sample per DATA_VALID_IN strobe and compares the sample magnitude against a runtime threshold. On each detected event it emits a one-cycle flag carrying the peak magnitude, then holds off re-triggering for a programmable dead time. It feeds the event/packet framing logic.

Parameters:
BITWIDTH, 16, sample width of DATA_IN, THRESHOLD, PEAK_OUT
SIGNED_DATA, 1, 1: DATA_IN is two's complement; 0: DATA_IN is offset-binary (midscale 1<<(BITWIDTH-1) = zero)
DEAD_TIME, 32, number of valid samples ignored after each event (1..255)
MAX_WIDTH, 64, maximum samples spent above threshold before an event is forced (1..255)
CNT_WIDTH, 16, width of the event counter

Ports:
CLK  in  1  system clock
nRST  in  1  synchronous reset, active-low
EN  in  1  block enable; low forces IDLE
DATA_VALID_IN  in  1  one-cycle strobe: DATA_IN holds a new sample (MAVG DATA_VALID)
DATA_IN  in  BITWIDTH  filtered sample (MAVG DATA_OUT)
THRESHOLD  in  BITWIDTH-1  unsigned magnitude threshold; sampled on every valid strobe
SPIKE_FLAG  out  1  one-cycle pulse per detected event
PEAK_OUT  out  BITWIDTH-1  max magnitude of the last event; stable until next event
SPIKE_CNT  out  CNT_WIDTH  number of events since reset, saturating
BUSY  out  1  high in PEAK or DEAD

Behaviour:
- Reset (nRST low at a CLK edge): all outputs 0, FSM to IDLE, internal counters 0.
- Magnitude: SIGNED_DATA=1 -> mag=|DATA_IN|; most-negative value saturates to 2^(BITWIDTH-1)-1. SIGNED_DATA=0 -> DATA_IN minus midscale, then the same rule. mag width BITWIDTH-1.
- Samples are processed only on cycles with EN=1 and DATA_VALID_IN=1. All other cycles leave state unchanged.
- FSM:
  - IDLE: entered whenever EN=0, from any state, on the next edge. An event in progress is aborted: no flag, PEAK_OUT/SPIKE_CNT kept. EN=1 -> ARMED.
  - ARMED: valid sample with mag > THRESHOLD (strictly) -> PEAK; peak_reg=mag, width_cnt=1. mag == THRESHOLD does not trigger.
  - PEAK: each valid sample updates peak_reg=max(peak_reg,mag). If mag <= THRESHOLD, or width_cnt reaches MAX_WIDTH, the event ends. On event end: SPIKE_FLAG=1 for exactly one cycle on the edge after the strobe; PEAK_OUT=peak_reg (including the ending sample); SPIKE_CNT+1, saturating at all-ones; dead_cnt=0; go to DEAD.
  - DEAD: each valid sample increments dead_cnt. After DEAD_TIME samples -> ARMED. A sample above threshold during DEAD is ignored.
- Latency: SPIKE_FLAG is asserted 1 CLK after the terminating DATA_VALID_IN cycle.
- Back-to-back DATA_VALID_IN on consecutive cycles must be handled: one sample per cycle, no drops.
- THRESHOLD changes take effect on the next valid sample. No glitch on SPIKE_FLAG.
- BUSY = (state==PEAK || state==DEAD), registered.

Optional Feature:
SPIKE_DET_TIMESTAMP_EN:
- Defined: adds output TIMESTAMP [31:0] and a 32-bit sample counter. The counter increments on every processed valid sample, wraps at 2^32, is cleared by reset, and holds while EN=0. The counter value of the sample that entered PEAK is latched and presented on TIMESTAMP in the same cycle as SPIKE_FLAG. TIMESTAMP resets to 0.
- Undefined: no port, no counter logic.

Test Plan:
1. Reset/idle: nRST low 3 cycles, then EN=0 with strobes of DATA_IN=0x7FFF -> all outputs stay 0, no SPIKE_FLAG.
2. Basic event (SIGNED_DATA=1, THRESHOLD=100, DEAD_TIME=4): samples 10,150,300,200,50 -> one SPIKE_FLAG 1 cycle after the strobe of sample 50, PEAK_OUT=300, SPIKE_CNT=1.
3. Boundaries: sample -32768 with THRESHOLD=32766 -> triggers, PEAK_OUT=0x7FFF. Sample exactly 100 with THRESHOLD=100 -> no trigger.
4. Dead time: with DEAD_TIME=4, an event followed by samples 500,500,500,500,500,20 -> 4 samples ignored, 5th 500 retriggers, second flag after the 20, SPIKE_CNT=2.
5. Forced end: MAX_WIDTH=8, 20 consecutive samples of 1000 at back-to-back strobes -> flag after the 8th sample, PEAK_OUT=1000, then DEAD.
6. Abort: EN dropped mid-PEAK after samples 150,300 -> no flag, SPIKE_CNT unchanged, BUSY=0 next cycle. Re-enable, then samples 150,0 -> flag with PEAK_OUT=150.
